video_muldiv_arbiter: RTL and testbench
=======================================

Name: video_muldiv_arbiter

Overview:
Shares one sys_udiv (24/12) and one sys_umul (12x12) engine among NREQ requesters in the CLK_VIDEO domain. Typical requesters are integer-scale, aspect-ratio and crop calculators. The block arbitrates round-robin, drives the engine start/operand ports and returns each result to its requester with a one-cycle ack. It also traps divide-by-zero and engine hangs, so a stuck engine never deadlocks the video path.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO, 64, max cycles the engine run signal may stay high before the op is aborted

Ports:
CLK_VIDEO  in  1  video clock
RESET_n  in  1  asynchronous active-low reset
req  in  NREQ  level request, one bit per requester; held until ack
req_op  in  NREQ  per-requester op: 0=multiply, 1=divide
req_a  in  24*NREQ  requester i operand A at [24i+23:24i]; mul uses [11:0]
req_b  in  12*NREQ  requester i operand B at [12i+11:12i]
ack  out  NREQ  one-cycle pulse to the granted requester; res/err valid in that cycle
res  out  24  result
err  out  1  result invalid (div-by-zero or timeout), valid with ack
busy  out  1  high in every state except IDLE
div_start  out  1  divider start pulse
div_run  in  1  divider busy
div_num  out  24  dividend
div_den  out  12  divisor
div_res  in  24  quotient
mul_start  out  1  multiplier start pulse
mul_run  in  1  multiplier busy
mul_arg1  out  12  multiplicand
mul_arg2  out  12  multiplier
mul_res  in  24  product

Behaviour:
- Reset (async, RESET_n=0): state=IDLE, rr_ptr=0, all outputs and operand registers 0, timeout counter 0.
- States: IDLE, ISSUE, SETTLE, WAIT, DONE, GAP.
- IDLE, grant rule:
  - Grant requires any req bit set and div_run=0 and mul_run=0.
  - Winner is the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - Latch idx, op, A, B. Go to ISSUE.
  - A request arriving while either run is high stays pending in IDLE.
- Divide-by-zero: granted op=1 with B==0 skips the engine and goes IDLE->DONE with res=24'hFFFFFF, err=1. Neither start pulses.
- ISSUE (1 cycle): pulse div_start or mul_start for the latched op. The other start stays 0. Go to SETTLE.
- Operand ports: div_num/div_den or mul_arg1/mul_arg2 are driven from the latched registers and stay stable from ISSUE through DONE. mul_arg1=A[11:0], mul_arg2=B.
- SETTLE (1 cycle): run is ignored, covering engine start latency. Clear the timeout counter. Go to WAIT.
- WAIT, completion: when the selected run=0, capture div_res or mul_res into res with err=0, then go to DONE.
- WAIT, timeout: the counter increments every cycle run=1. When it reaches TMO, set res=0, err=1 and go to DONE. This is the only abort path.
- DONE (1 cycle):
  - ack[idx]=1, res/err held.
  - rr_ptr <= (idx+1) mod NREQ.
  - Go to GAP.
- GAP (1 cycle): no grant. A requester deasserts req on the edge where it sees ack, and GAP guarantees that deassertion is seen before the next grant. Go to IDLE.
- Pending requests: req still high in IDLE after GAP is a new request.
- Withdrawn requests: dropping req mid-operation does not abort. The op completes and ack still pulses; the requester ignores it.
- Operand stability: operand changes on req_a/req_b after grant have no effect.
- Latency:
  - Grant-edge to ack is 4+K cycles, where K is the number of engine run-high cycles after SETTLE.
  - Div-by-zero grant to ack is 1 cycle.
  - Minimum ack-to-next-grant spacing is 2 cycles.
- Simultaneous events:
  - All NREQ requesting: grants rotate strictly in index order starting at rr_ptr.
  - A req bit rising in the same cycle as ack for another requester is eligible at the next IDLE.
- Outputs: ack, res, err and busy are registered. busy=0 only in IDLE.
- Reset mid-operation: the arbiter returns to IDLE immediately. The engine may still be running, so the IDLE run-low check holds off new grants until the engine finishes. No ack is issued for the aborted op.

Test Plan:
- Single mul: req[0], op=0, A=0x000100, B=0x00A; mul model K=3 -> one mul_start, ack[0] exactly 7 cycles after grant edge, res=0x000A00, err=0.
- Single div: req[2], op=1, A=24'd1080, B=12'd240 -> div_start only, res=4, err=0; div_num/div_den stable ISSUE..DONE.
- Contention: all 4 req high, each holding req until its ack then re-raising -> ack order 0,1,2,3,0; never two acks within 2 cycles; ack strictly sequential.
- Div-by-zero: req[1], op=1, B=0 -> no div_start, ack[1] 1 cycle after grant, res=0xFFFFFF, err=1.
- Timeout: TMO=64, div model holds div_run high forever -> ack at cycle 64 of WAIT with res=0, err=1; next req not granted until div_run falls.
- Reset mid-op: assert RESET_n=0 during WAIT with mul_run high -> ack/busy 0 asynchronously; after release, pending req[3] is granted only after mul_run=0, and ack[3] carries the correct product.

Source files
------------

// File: rtl/video_muldiv_arbiter.sv
// video_muldiv_arbiter: round-robin share of one 24/12 divider and one 12x12 multiplier among NREQ requesters.
// Latency: grant to ack is 4+K cycles (K = engine run-high cycles after settle); divide-by-zero acks 1 cycle after grant.
// Backpressure: requests are held levels until ack; no grant while either engine runs, and a hung engine is aborted after TMO cycles.
module video_muldiv_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic                 CLK_VIDEO,
    input  logic                 RESET_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [24*NREQ-1:0]   req_a,
    input  logic [12*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      ack,
    output logic [23:0]          res,
    output logic                 err,
    output logic                 busy,
    output logic                 div_start,
    input  logic                 div_run,
    output logic [23:0]          div_num,
    output logic [11:0]          div_den,
    input  logic [23:0]          div_res,
    output logic                 mul_start,
    input  logic                 mul_run,
    output logic [11:0]          mul_arg1,
    output logic [11:0]          mul_arg2,
    input  logic [23:0]          mul_res
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_DONE, S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_rr_ptr;
    logic              r_op;
    logic [23:0]       r_a;
    logic [11:0]       r_b;
    logic [23:0]       r_res;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_busy;

    logic [23:0]       w_a [NREQ];
    logic [11:0]       w_b [NREQ];
    logic              w_gnt_vld;
    logic [IW-1:0]     w_gnt_idx;
    logic [IW:0]       w_scan;
    logic              w_grant;
    logic              w_gnt_dz;
    logic              w_run;
    logic              w_tmo;
    logic [IW-1:0]     w_ack_idx;
    logic [NREQ-1:0]   w_ack_vec;
    logic              w_div_start;
    logic              w_mul_start;

    // Unpack the flat per-requester operand buses into lanes
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_a[i] = req_a[24*i +: 24];
            w_b[i] = req_b[12*i +: 12];
        end
    end

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_scan = {1'b0, r_rr_ptr} + (IW+1)'(i);
            if (w_scan >= (IW+1)'(NREQ)) begin
                w_scan = w_scan - (IW+1)'(NREQ);
            end
            if (req[w_scan[IW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan[IW-1:0];
            end
        end
    end

    // Grant only with both engines idle, so an engine still running after a reset is never restarted
    assign w_grant   = (r_state == S_IDLE) && w_gnt_vld && !div_run && !mul_run;
    assign w_gnt_dz  = req_op[w_gnt_idx] && (w_b[w_gnt_idx] == 12'd0);
    assign w_run     = r_op ? div_run : mul_run;
    assign w_tmo     = w_run && (r_cnt == CW'(TMO - 1));
    assign w_ack_idx = (r_state == S_IDLE) ? w_gnt_idx : r_idx;
    assign w_ack_vec = NREQ'(1) << w_ack_idx;

    // State register
    always_ff @(posedge CLK_VIDEO or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the timeout is the only way out of WAIT while run stays high
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_next = w_gnt_dz ? S_DONE : S_ISSUE;
            S_ISSUE:  w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT:   if (!w_run || w_tmo) w_next = S_DONE;
            S_DONE:   w_next = S_GAP;
            S_GAP:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Engine start pulses for the latched op, only in ISSUE
    always_comb begin
        w_div_start = 1'b0;
        w_mul_start = 1'b0;
        if (r_state == S_ISSUE) begin
            w_div_start = r_op;
            w_mul_start = !r_op;
        end
    end

    // Datapath: operand latch at grant, result capture, timeout count, pointer advance, registered ack/busy
    always_ff @(posedge CLK_VIDEO or negedge RESET_n) begin
        if (!RESET_n) begin
            r_idx    <= '0;
            r_rr_ptr <= '0;
            r_op     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_idx <= w_gnt_idx;
                        r_op  <= req_op[w_gnt_idx];
                        r_a   <= w_a[w_gnt_idx];
                        r_b   <= w_b[w_gnt_idx];
                        if (w_gnt_dz) begin
                            r_res <= 24'hFFFFFF;
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SETTLE: r_cnt <= '0;
                S_WAIT: begin
                    if (!w_run) begin
                        r_res <= r_op ? div_res : mul_res;
                        r_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
                end
                default: ;
            endcase
            r_ack  <= (w_next == S_DONE) ? w_ack_vec : '0;
            r_busy <= (w_next != S_IDLE);
        end
    end

    assign ack       = r_ack;
    assign res       = r_res;
    assign err       = r_err;
    assign busy      = r_busy;
    assign div_start = w_div_start;
    assign mul_start = w_mul_start;
    assign div_num   = r_a;
    assign div_den   = r_b;
    assign mul_arg1  = r_a[11:0];
    assign mul_arg2  = r_b;

endmodule

// File: tb/tb_video_muldiv_arbiter.sv
// Bench for video_muldiv_arbiter: directed steps with simple multiplier/divider engine models.
module tb_video_muldiv_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 64;

    logic                CLK_VIDEO = 1'b0;
    logic                RESET_n   = 1'b0;
    logic [NREQ-1:0]     req       = '0;
    logic [NREQ-1:0]     req_op    = '0;
    logic [24*NREQ-1:0]  req_a     = '0;
    logic [12*NREQ-1:0]  req_b     = '0;
    logic [NREQ-1:0]     ack;
    logic [23:0]         res;
    logic                err;
    logic                busy;
    logic                div_start;
    logic                div_run   = 1'b0;
    logic [23:0]         div_num;
    logic [11:0]         div_den;
    logic [23:0]         div_res   = '0;
    logic                mul_start;
    logic                mul_run   = 1'b0;
    logic [11:0]         mul_arg1;
    logic [11:0]         mul_arg2;
    logic [23:0]         mul_res   = '0;

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    video_muldiv_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .RESET_n   (RESET_n),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .res       (res),
        .err       (err),
        .busy      (busy),
        .div_start (div_start),
        .div_run   (div_run),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_res   (div_res),
        .mul_start (mul_start),
        .mul_run   (mul_run),
        .mul_arg1  (mul_arg1),
        .mul_arg2  (mul_arg2),
        .mul_res   (mul_res)
    );

    // Engine models: run rises the edge after start and stays high for *_len cycles; *_hang freezes it high
    int   mul_len  = 4;
    int   div_len  = 3;
    logic mul_hang = 1'b0;
    logic div_hang = 1'b0;
    int   m_left   = 0;
    int   d_left   = 0;

    always @(posedge CLK_VIDEO) begin
        if (mul_start) begin
            m_left  <= mul_len;
            mul_run <= 1'b1;
            mul_res <= 24'(mul_arg1) * 24'(mul_arg2);
        end else if (m_left > 0 && !mul_hang) begin
            m_left <= m_left - 1;
            if (m_left == 1) mul_run <= 1'b0;
        end
    end

    always @(posedge CLK_VIDEO) begin
        if (div_start) begin
            d_left  <= div_len;
            div_run <= 1'b1;
            div_res <= (div_den == 12'd0) ? 24'hFFFFFF : div_num / 24'(div_den);
        end else if (d_left > 0 && !div_hang) begin
            d_left <= d_left - 1;
            if (d_left == 1) div_run <= 1'b0;
        end
    end

    // Monitors: start pulse counts and ack shape/spacing
    int n_mstart  = 0;
    int n_dstart  = 0;
    int ack_viol  = 0;
    int since_ack = 100;

    always @(posedge CLK_VIDEO) begin
        if (mul_start) n_mstart++;
        if (div_start) n_dstart++;
        if (ack != '0) begin
            if (!$onehot(ack) || since_ack < 2) ack_viol++;
            since_ack = 0;
        end else if (since_ack < 100) begin
            since_ack++;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic op, input logic [23:0] a, input logic [11:0] b);
        req_op[i]        = op;
        req_a[24*i +: 24] = a;
        req_b[12*i +: 12] = b;
        req[i]           = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_VIDEO);
    endtask

    // Wait for grant, then for ack. Cycle 1 is the first cycle with busy high.
    // Operand inputs are scrambled right after the grant; operand outputs are tracked for stability.
    task automatic run_op(input int limit, output int cyc, output logic [NREQ-1:0] a,
                          output logic sm, output logic sd, output logic stable,
                          output logic [23:0] n0, output logic [11:0] d0);
        int t;
        logic [11:0] a1, a2;
        t = 0;
        while (busy !== 1'b1 && t < limit) begin
            @(negedge CLK_VIDEO);
            t++;
        end
        chk("grant_seen", 32'(busy), 32'd1);
        cyc    = 1;
        sm     = mul_start;
        sd     = div_start;
        n0     = div_num;
        d0     = div_den;
        a1     = mul_arg1;
        a2     = mul_arg2;
        stable = 1'b1;
        req_a  = '1;
        req_b  = '1;
        while (ack === '0 && cyc < limit) begin
            @(negedge CLK_VIDEO);
            cyc++;
            if (div_num !== n0 || div_den !== d0 || mul_arg1 !== a1 || mul_arg2 !== a2) stable = 1'b0;
        end
        a = ack;
    endtask

    task automatic wait_ack(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK_VIDEO);
            cyc++;
        end while (ack === '0 && cyc < limit);
    endtask

    initial begin
        int              cyc;
        logic [NREQ-1:0] a;
        logic            sm, sd, stable, seen;
        logic [23:0]     n0;
        logic [11:0]     d0;
        int              m0, dcount;
        int              exp_ord [5] = '{0, 1, 2, 3, 0};
        logic [23:0]     exp_p   [4] = '{24'h50, 24'h72, 24'h9A, 24'hC8};

        // Reset state
        idle(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_res",  32'(res),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_starts", 32'({div_start, mul_start}), 32'd0);
        chk("rst_operands", 32'({div_den, mul_arg1}), 32'd0);
        RESET_n = 1'b1;
        idle(2);

        // Contention: all four multiply requests, each re-raised after its ack
        mul_len = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 24'(16 + 3*i), 12'(5 + i));
        for (int k = 0; k < 5; k++) begin
            wait_ack(50, cyc);
            chk($sformatf("cont_ack%0d", k), 32'(ack), 32'(4'b0001 << exp_ord[k]));
            chk($sformatf("cont_res%0d", k), 32'(res), 32'(exp_p[exp_ord[k]]));
            req[exp_ord[k]] = 1'b0;
            @(negedge CLK_VIDEO);
            if (k < 4) req[exp_ord[k]] = 1'b1;
            else       req = '0;
        end
        idle(3);

        // Single multiply with K=3
        mul_len = 4;
        m0 = n_mstart;
        dcount = n_dstart;
        set_req(0, 1'b0, 24'h000100, 12'h00A);
        run_op(30, cyc, a, sm, sd, stable, n0, d0);
        chk("mul_issue_start", 32'({sm, sd}), 32'(2'b10));
        chk("mul_ack_cycle", 32'(cyc), 32'd7);
        chk("mul_ack", 32'(a), 32'(4'b0001));
        chk("mul_res", 32'(res), 32'h000A00);
        chk("mul_err", 32'(err), 32'd0);
        req[0] = 1'b0;
        @(negedge CLK_VIDEO);
        chk("gap_busy_ack", 32'({busy, ack}), 32'({1'b1, 4'b0000}));
        @(negedge CLK_VIDEO);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("mul_start_count", 32'(n_mstart - m0), 32'd1);
        chk("mul_no_div_start", 32'(n_dstart - dcount), 32'd0);

        // Single divide with K=2
        div_len = 3;
        set_req(2, 1'b1, 24'd1080, 12'd240);
        run_op(30, cyc, a, sm, sd, stable, n0, d0);
        chk("div_issue_start", 32'({sm, sd}), 32'(2'b01));
        chk("div_operands", 32'({n0, 8'h00}) | 32'(d0), 32'({24'd1080, 8'h00}) | 32'd240);
        chk("div_ack_cycle", 32'(cyc), 32'd6);
        chk("div_ack", 32'(a), 32'(4'b0100));
        chk("div_res", 32'(res), 32'd4);
        chk("div_err", 32'(err), 32'd0);
        chk("div_operand_stable", 32'(stable), 32'd1);
        req[2] = 1'b0;
        idle(2);

        // Divide by zero bypasses the engine
        dcount = n_dstart;
        set_req(1, 1'b1, 24'h001234, 12'h000);
        run_op(30, cyc, a, sm, sd, stable, n0, d0);
        chk("dz_ack_cycle", 32'(cyc), 32'd1);
        chk("dz_ack", 32'(a), 32'(4'b0010));
        chk("dz_res", 32'(res), 32'hFFFFFF);
        chk("dz_err", 32'(err), 32'd1);
        req[1] = 1'b0;
        idle(2);
        chk("dz_no_div_start", 32'(n_dstart - dcount), 32'd0);

        // Timeout: divider run stuck high
        div_len  = 3;
        div_hang = 1'b1;
        set_req(2, 1'b1, 24'd100, 12'd5);
        run_op(200, cyc, a, sm, sd, stable, n0, d0);
        chk("tmo_ack_cycle", 32'(cyc), 32'(3 + TMO));
        chk("tmo_ack", 32'(a), 32'(4'b0100));
        chk("tmo_res", 32'(res), 32'd0);
        chk("tmo_err", 32'(err), 32'd1);
        req[2] = 1'b0;
        mul_len = 2;
        set_req(0, 1'b0, 24'h000020, 12'h003);
        idle(1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK_VIDEO);
            if (busy || ack != '0) seen = 1'b1;
        end
        chk("tmo_holdoff", 32'(seen), 32'd0);
        div_hang = 1'b0;
        run_op(40, cyc, a, sm, sd, stable, n0, d0);
        chk("post_tmo_ack", 32'(a), 32'(4'b0001));
        chk("post_tmo_res", 32'(res), 32'h60);
        chk("post_tmo_err", 32'(err), 32'd0);
        req[0] = 1'b0;
        idle(3);

        // Reset during WAIT with the multiplier stuck busy
        mul_len  = 4;
        mul_hang = 1'b1;
        set_req(3, 1'b0, 24'h000123, 12'h010);
        cyc = 0;
        while (busy !== 1'b1 && cyc < 20) begin
            @(negedge CLK_VIDEO);
            cyc++;
        end
        chk("rst_mid_grant", 32'(busy), 32'd1);
        idle(3);
        #2 RESET_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_operand", 32'(mul_arg1), 32'd0);
        @(negedge CLK_VIDEO);
        RESET_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK_VIDEO);
            if (busy || ack != '0) seen = 1'b1;
        end
        chk("rst_mid_holdoff", 32'(seen), 32'd0);
        mul_hang = 1'b0;
        run_op(40, cyc, a, sm, sd, stable, n0, d0);
        chk("rst_mid_ack3", 32'(a), 32'(4'b1000));
        chk("rst_mid_res", 32'(res), 32'h001230);
        chk("rst_mid_err", 32'(err), 32'd0);
        req[3] = 1'b0;
        idle(3);

        chk("ack_shape_spacing", 32'(ack_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
